// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit with valid/ready handshakes.
// A single beat produces f(a,b). An accumulate burst folds successive A
// operands into one result, with a saturating count of the beats folded.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [CW-1:0]    out_count,
  output logic             out_zero
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic [CW-1:0]    out_count_q, out_count_d;
  logic             out_zero_q, out_zero_d;

  logic             accept_s;
  logic [CW-1:0]    cnt_inc_s;
  logic [WIDTH-1:0] fold_s;

  // Bitwise operation selected by o; the NOT A and pass A codes ignore y.
  function automatic logic [WIDTH-1:0] f_op(input logic [2:0] o,
                                            input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y);
    case (o)
      3'b000:  f_op = x & y;
      3'b001:  f_op = x | y;
      3'b010:  f_op = x ^ y;
      3'b011:  f_op = ~(x & y);
      3'b100:  f_op = ~(x | y);
      3'b101:  f_op = ~(x ^ y);
      3'b110:  f_op = ~x;
      3'b111:  f_op = x;
      default: f_op = x & y;
    endcase
  endfunction

  // A new beat may enter when the output slot is empty or being drained now.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept_s  = in_valid && in_ready;
  assign cnt_inc_s = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
  assign fold_s    = f_op(op_q, acc_q, in_a);

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_count = out_count_q;
  assign out_zero  = out_zero_q;

  // Next-state logic: the FSM, the burst accumulator and the output slot.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_y_d     = out_y_q;
    out_count_d = out_count_q;
    out_valid_d = out_ready ? 1'b0 : out_valid_q;
    if (accept_s) begin
      case (state_q)
        S_IDLE: begin
          if (!acc) begin
            out_y_d     = f_op(op, in_a, in_b);
            out_count_d = CW'(1);
            out_valid_d = 1'b1;
          end else if (last) begin
            out_y_d     = in_a;
            out_count_d = CW'(1);
            out_valid_d = 1'b1;
          end else begin
            op_d    = op;
            acc_d   = in_a;
            cnt_d   = CW'(1);
            state_d = S_ACCUM;
          end
        end
        S_ACCUM: begin
          acc_d = fold_s;
          cnt_d = cnt_inc_s;
          if (last) begin
            out_y_d     = fold_s;
            out_count_d = cnt_inc_s;
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_ACCUM;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    out_zero_d = (out_y_d == {WIDTH{1'b0}});
  end

  // All state registers, cleared asynchronously by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 3'b000;
      acc_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      out_y_q     <= {WIDTH{1'b0}};
      out_count_q <= {CW{1'b0}};
      out_zero_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_count_q <= out_count_d;
      out_zero_q  <= out_zero_d;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: three instances (8/8, 1/8 and 8/2 widths)
// receive identical stimulus; a scoreboard queue holds expected results and
// a monitor checks every presented result against it.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, acc, last;
  logic [2:0] op;
  logic [7:0] in_a, in_b;

  logic       rdy8, v8, z8;
  logic [7:0] y8, c8;
  logic       rdy1, v1, z1;
  logic [0:0] y1;
  logic [7:0] c1;
  logic       rdy2, v2, z2;
  logic [7:0] y2;
  logic [1:0] c2;

  logic [0:0] a1, b1;
  assign a1 = in_a[0:0];
  assign b1 = in_b[0:0];

  logic_unit_pipe #(.WIDTH(8), .CW(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy8),
    .in_a(in_a), .in_b(in_b), .op(op), .acc(acc), .last(last),
    .out_valid(v8), .out_ready(out_ready), .out_y(y8), .out_count(c8),
    .out_zero(z8));

  logic_unit_pipe #(.WIDTH(1), .CW(8)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_a(a1), .in_b(b1), .op(op), .acc(acc), .last(last),
    .out_valid(v1), .out_ready(out_ready), .out_y(y1), .out_count(c1),
    .out_zero(z1));

  logic_unit_pipe #(.WIDTH(8), .CW(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_a(in_a), .in_b(in_b), .op(op), .acc(acc), .last(last),
    .out_valid(v2), .out_ready(out_ready), .out_y(y2), .out_count(c2),
    .out_zero(z2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] y;
    int         cnt;
    int         due;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int nres  = 0;
  logic       held = 1'b0;
  logic [7:0] hy;
  int         hc;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Offer one beat, wait (bounded) for acceptance, and queue its expected result.
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] o, input logic ac, input logic la,
                      input logic has_out, input logic [7:0] ey, input int ec);
    int w;
    exp_t e;
    in_valid = 1'b1; in_a = a; in_b = b; op = o; acc = ac; last = la;
    w = 0;
    @(negedge clk);
    while (!rdy8 && w < 50) begin
      w++;
      @(negedge clk);
    end
    chk("in_ready_at_accept", rdy8, 1);
    if (has_out) begin
      e.y = ey; e.cnt = ec; e.due = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: pop and compare on first appearance, check stability while held.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else if (v8) begin
        if (!held) begin
          chk("sb_has_entry", q.size() != 0, 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            nres++;
            chk("y8", y8, e.y);
            chk("count8", c8, e.cnt);
            chk("zero8", z8, e.y == 8'h00);
            chk("latency", cyc, e.due);
            chk("valid1", v1, 1);
            chk("y1", y1, e.y[0]);
            chk("count1", c1, e.cnt);
            chk("zero1", z1, !e.y[0]);
            chk("valid2", v2, 1);
            chk("y2", y2, e.y);
            chk("count2_sat", c2, (e.cnt > 3) ? 3 : e.cnt);
            hy = e.y; hc = e.cnt; held = 1'b1;
          end
        end else begin
          chk("hold_y", y8, hy);
          chk("hold_count", c8, hc);
          chk("hold_zero", z8, hy == 8'h00);
        end
        if (out_ready) held = 1'b0;
      end
    end
  end

  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    acc = 1'b0; last = 1'b0; op = 3'b000; in_a = 8'h00; in_b = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_valid", v8, 0);
    chk("rst_y", y8, 0);
    chk("rst_count", c8, 0);
    chk("rst_zero", z8, 1);
    chk("rst_in_ready", rdy8, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // OR truth table on consecutive cycles
    send(8'h00, 8'h00, 3'b001, 1'b0, 1'b0, 1'b1, 8'h00, 1);
    send(8'h00, 8'h01, 3'b001, 1'b0, 1'b0, 1'b1, 8'h01, 1);
    send(8'h01, 8'h00, 3'b001, 1'b0, 1'b0, 1'b1, 8'h01, 1);
    send(8'h01, 8'h01, 3'b001, 1'b0, 1'b0, 1'b1, 8'h01, 1);

    // AND, then XOR held off by backpressure
    send(8'hF0, 8'h3C, 3'b000, 1'b0, 1'b0, 1'b1, 8'h30, 1);
    out_ready = 1'b0;
    fork
      send(8'h5A, 8'h5A, 3'b010, 1'b0, 1'b0, 1'b1, 8'h00, 1);
      begin
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready", rdy8, 0);
          chk("bp_y", y8, 8'h30);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join

    // Remaining operations, back to back
    send(8'hF0, 8'h3C, 3'b011, 1'b0, 1'b0, 1'b1, 8'hCF, 1);
    send(8'hF0, 8'h3C, 3'b100, 1'b0, 1'b0, 1'b1, 8'h03, 1);
    send(8'hF0, 8'h3C, 3'b101, 1'b0, 1'b0, 1'b1, 8'h33, 1);
    send(8'hF0, 8'h3C, 3'b110, 1'b0, 1'b0, 1'b1, 8'h0F, 1);
    send(8'hF0, 8'h3C, 3'b111, 1'b0, 1'b0, 1'b1, 8'hF0, 1);

    // One-beat accumulate burst passes A through
    send(8'hA5, 8'h00, 3'b000, 1'b1, 1'b1, 1'b1, 8'hA5, 1);

    // XOR accumulate burst
    send(8'h01, 8'h00, 3'b010, 1'b1, 1'b0, 1'b0, 8'h00, 0);
    send(8'h02, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    send(8'h04, 8'h00, 3'b000, 1'b0, 1'b1, 1'b1, 8'h07, 3);

    // OR burst abandoned by reset, then a plain AND
    send(8'h11, 8'h00, 3'b001, 1'b1, 1'b0, 1'b0, 8'h00, 0);
    send(8'h22, 8'h00, 3'b001, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", v8, 0);
    chk("async_rst_count", c8, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send(8'hFF, 8'h0F, 3'b000, 1'b0, 1'b0, 1'b1, 8'h0F, 1);

    // Five-beat AND burst: 8-bit count reaches 5, 2-bit count saturates at 3
    send(8'hFF, 8'h00, 3'b000, 1'b1, 1'b0, 1'b0, 8'h00, 0);
    send(8'hFF, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    send(8'hFF, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    send(8'hFF, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 8'h00, 0);
    send(8'h81, 8'h00, 3'b000, 1'b0, 1'b1, 1'b1, 8'h81, 5);

    w = 0;
    while (q.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    chk("result_count", nres, 15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, registered successor to the single-bit gate primitives. The block applies one of eight bitwise logic operations to two WIDTH-bit operands. It can also fold a multi-beat burst into a single result through an internal accumulator. Operands and results move over valid/ready handshakes, and the block sits between operand producers and any consumer that needs a registered, flow-controlled logic result.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- CW, 8, beat-counter width in bits (≥1)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B (ignored in accumulate mode)
- op  input  3  operation: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A, 111 pass A
- acc  input  1  start an accumulate burst (sampled on first beat only)
- last  input  1  final beat of an accumulate burst
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_y  output  WIDTH  result
- out_count  output  CW  number of beats folded into out_y (saturating)
- out_zero  output  1  out_y == 0

## Operation
- Accept rule: accept = in_valid && in_ready, with in_ready = !out_valid || out_ready (combinational).
- f(x,y) is the bitwise op selected; NOT A gives ~x, and pass A gives x.
- The FSM has two states, IDLE and ACCUM.
- In IDLE, an accept with acc=0 loads out_y=f(in_a,in_b) and out_count=1, asserts out_valid, and stays in IDLE.
- In IDLE, an accept with acc=1 and last=1 loads out_y=in_a and out_count=1, and asserts out_valid.
- In IDLE, an accept with acc=1 and last=0 latches op into op_r, sets acc_r=in_a and cnt_r=1, goes to ACCUM, and produces no output.
- In ACCUM, each accept updates acc_r=f(acc_r,in_a) using op_r. The cnt_r register is incremented and saturates at 2^CW−1. The op and acc inputs are ignored.
- In ACCUM, an accept with last=1 loads out_y with the folded value and out_count with the incremented count, asserts out_valid, and returns to IDLE.
- No output is produced for non-last beats.
- Output hold: while out_valid=1 and out_ready=0, out_y, out_count and out_zero stay stable.
- out_zero is derived from the out_y register.
- Reset values: out_valid=0, out_y=0, out_count=0, out_zero=1, state=IDLE, acc_r=0, cnt_r=0, op_r=000.
- in_ready is 1 out of reset.
- Reset mid-burst: any partial accumulation is discarded with no output, and the next accepted beat is treated as an IDLE beat.
- Same-cycle events: a result can be consumed and a new beat accepted in the same cycle (out_ready=1 with in_valid=1), which gives full throughput.
- If the last beat is accepted while the previous result is leaving in the same cycle, the new result replaces it with no bubble.

## Timing
- Latency: the result appears one clock after the accepting edge of the last (or only) beat.
- Throughput: one beat per clock while out_ready=1.
- The non-last accumulate beats are absorbed at one per clock, with no output.
- in_ready depends combinationally on out_ready. There is no combinational path from in_* to out_*.
- rst_n assertion clears all registers immediately, without waiting for a clock. Deassertion takes effect from the next rising edge.

## Test plan
- WIDTH=1, op=001 (OR), (a,b)=00,01,10,11 on consecutive cycles with out_ready=1 → out_y=0,1,1,1, each one cycle after accept, with out_count=1 every time.
- WIDTH=8, op=000 (AND), a=0xF0, b=0x3C → out_y=0x30, out_zero=0. Then op=010 (XOR) with a=b=0x5A → out_y=0x00, out_zero=1.
- Accumulate XOR burst: acc=1, a=0x01, then 0x02, then 0x04 with last=1 → out_valid stays low for the first two beats, then one result with out_y=0x07 and out_count=3.
- Backpressure: after the AND result 0x30, hold out_ready=0 for 4 cycles with in_valid=1 → in_ready=0, and out_y stays 0x30 and stable. When out_ready rises, the pending beat is accepted in that cycle and its result appears on the next cycle.
- Reset mid-burst: an OR burst with 0x11 then 0x22 (no last), then rst_n=0 for 1 cycle → out_valid=0 and out_count=0. Next, a single AND of 0xFF and 0x0F gives out_y=0x0F, not an accumulated value.
- Saturation with CW=2: a 5-beat AND burst of 0xFF ×4 then 0x81 (last) → out_y=0x81, out_count=3.
